sdram_avalon_responder: RTL

Avalon-MM slave that answers the SDRAM-side master port (16-bit data, 25-bit word address, 2-bit byteenable). It backs the address space with an on-chip word array and inserts configurable waitrequest stalls and a fixed read latency. It lets memory-access masters in the raytracer be simulated and tested on the FPGA without the SDRAM controller, and it checks their handshake behaviour.

---
 rtl/sdram_avalon_responder_if.sv | 30 +++
 rtl/sdram_avalon_responder.sv | 110 +++++++++++
 2 files changed

// File: rtl/sdram_avalon_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sdram_avalon_responder_if
// Brief  : Avalon-MM bus bundle for the SDRAM-side master port.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface sdram_avalon_responder_if;
    logic [24:0] sdram_address;
    logic [1:0]  sdram_byteenable;
    logic [15:0] sdram_writedata;
    logic        sdram_read;
    logic        sdram_write;
    logic        sdram_chipselect;
    logic [15:0] sdram_readdata;
    logic        sdram_waitrequest;
    logic        sdram_readdatavalid;

    modport master (
        output sdram_address, sdram_byteenable, sdram_writedata,
               sdram_read, sdram_write, sdram_chipselect,
        input  sdram_readdata, sdram_waitrequest, sdram_readdatavalid
    );

    modport slave (
        input  sdram_address, sdram_byteenable, sdram_writedata,
               sdram_read, sdram_write, sdram_chipselect,
        output sdram_readdata, sdram_waitrequest, sdram_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/sdram_avalon_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : sdram_avalon_responder
// Brief  : Avalon-MM slave backed by an on-chip word array, with programmable
//          waitrequest stalls, fixed read latency and protocol error flagging.
// Rev    : 1.0 - initial release
// ----------------------------------------------------------------------------
module sdram_avalon_responder #(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_CYCLES  = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    sdram_avalon_responder_if.slave bus,
    output logic                    err_flag,
    output logic [15:0]             cmd_count
);

    localparam int         c_depth    = 1 << DEPTH_LOG2;
    localparam logic [1:0] c_wait     = 2'(WAIT_CYCLES);
    localparam logic [15:0] c_oor_data = 16'hDEAD;

    logic [15:0]             r_mem [c_depth];
    logic [1:0]              r_wait_cnt;
    logic [READ_LATENCY-1:0] r_vld;
    logic [15:0]             r_dat [READ_LATENCY];
    logic                    r_err;
    logic [15:0]             r_cnt;

    logic                    w_cmd;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_is_write;
    logic                    w_is_read;
    logic                    w_both;
    logic [24-DEPTH_LOG2:0]  w_addr_hi;
    logic                    w_in_range;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [15:0]             w_rd_word;

    assign w_cmd      = bus.sdram_chipselect & (bus.sdram_read | bus.sdram_write);
    assign w_ready    = (r_wait_cnt == c_wait);
    assign w_accept   = w_cmd & w_ready & ~reset;
    // Simultaneous read+write resolves to a write.
    assign w_is_write = bus.sdram_write;
    assign w_is_read  = bus.sdram_read & ~bus.sdram_write;
    assign w_both     = bus.sdram_read & bus.sdram_write;

    assign w_addr_hi  = bus.sdram_address[24:DEPTH_LOG2];
    assign w_in_range = (w_addr_hi == '0);
    assign w_idx      = bus.sdram_address[DEPTH_LOG2-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : c_oor_data;

    assign bus.sdram_waitrequest   = reset | (w_cmd & ~w_ready);
    assign bus.sdram_readdatavalid = r_vld[READ_LATENCY-1];
    assign bus.sdram_readdata      = r_vld[READ_LATENCY-1] ? r_dat[READ_LATENCY-1] : 16'h0000;
    assign err_flag                = r_err;
    assign cmd_count               = r_cnt;

    // Backing store deliberately has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_write && w_in_range) begin
            if (bus.sdram_byteenable[0]) r_mem[w_idx][7:0]  <= bus.sdram_writedata[7:0];
            if (bus.sdram_byteenable[1]) r_mem[w_idx][15:8] <= bus.sdram_writedata[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 2'd0;
        end else if (!w_cmd || w_ready) begin
            r_wait_cnt <= 2'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_dat[i] <= 16'h0000;
            end
        end else begin
            r_vld[0] <= w_accept & w_is_read;
            if (w_accept && w_is_read) begin
                r_dat[0] <= w_rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
            r_cnt <= 16'h0000;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 16'h0001;
            if (w_both || !w_in_range) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
